// File: rtl/me_sad_pkg.sv
// Shared constants for the minimum-SAD drain path.
// Type codes, per-type counts, widths and stream offsets.
package me_sad_pkg;

    localparam int NUM_ENT = 100;

    localparam logic [2:0] SAD_T_4x8   = 3'd0;
    localparam logic [2:0] SAD_T_8x4   = 3'd1;
    localparam logic [2:0] SAD_T_8x8   = 3'd2;
    localparam logic [2:0] SAD_T_8x16  = 3'd3;
    localparam logic [2:0] SAD_T_16x8  = 3'd4;
    localparam logic [2:0] SAD_T_16x16 = 3'd5;

    localparam int CNT_4x8   = 32;
    localparam int CNT_8x4   = 32;
    localparam int CNT_8x8   = 16;
    localparam int CNT_8x16  = 8;
    localparam int CNT_16x8  = 8;
    localparam int CNT_16x16 = 4;

    localparam int W_4x8   = 13;
    localparam int W_8x4   = 13;
    localparam int W_8x8   = 14;
    localparam int W_8x16  = 15;
    localparam int W_16x8  = 15;
    localparam int W_16x16 = 16;

    localparam int BASE_4x8   = 0;
    localparam int BASE_8x4   = 32;
    localparam int BASE_8x8   = 64;
    localparam int BASE_8x16  = 80;
    localparam int BASE_16x8  = 88;
    localparam int BASE_16x16 = 96;

    localparam int SEL_W = 16;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

endpackage

// File: rtl/sad_entry_sel.sv
// Stream-position to entry mux for the SAD drain.
// Maps a flat counter onto {sad, type, idx} from the shadow vectors.
module sad_entry_sel
    import me_sad_pkg::*;
(
    input  logic [6:0]                    cnt,
    input  logic [CNT_4x8*W_4x8-1:0]      s4x8,
    input  logic [CNT_8x4*W_8x4-1:0]      s8x4,
    input  logic [CNT_8x8*W_8x8-1:0]      s8x8,
    input  logic [CNT_8x16*W_8x16-1:0]    s8x16,
    input  logic [CNT_16x8*W_16x8-1:0]    s16x8,
    input  logic [CNT_16x16*W_16x16-1:0]  s16x16,
    output logic [SEL_W-1:0]              sad,
    output logic [2:0]                    typ,
    output logic [4:0]                    idx
);

    int c;
    int rel;

    // Pick the partition group by range, then slice within it.
    always_comb begin
        sad = '0;
        typ = SAD_T_4x8;
        idx = '0;
        c   = int'(cnt);
        rel = 0;
        unique case (1'b1)
            (c < BASE_8x4): begin
                rel = c - BASE_4x8;
                sad = SEL_W'(s4x8[rel*W_4x8 +: W_4x8]);
                typ = SAD_T_4x8;
            end
            (c >= BASE_8x4 && c < BASE_8x8): begin
                rel = c - BASE_8x4;
                sad = SEL_W'(s8x4[rel*W_8x4 +: W_8x4]);
                typ = SAD_T_8x4;
            end
            (c >= BASE_8x8 && c < BASE_8x16): begin
                rel = c - BASE_8x8;
                sad = SEL_W'(s8x8[rel*W_8x8 +: W_8x8]);
                typ = SAD_T_8x8;
            end
            (c >= BASE_8x16 && c < BASE_16x8): begin
                rel = c - BASE_8x16;
                sad = SEL_W'(s8x16[rel*W_8x16 +: W_8x16]);
                typ = SAD_T_8x16;
            end
            (c >= BASE_16x8 && c < BASE_16x16): begin
                rel = c - BASE_16x8;
                sad = SEL_W'(s16x8[rel*W_16x8 +: W_16x8]);
                typ = SAD_T_16x8;
            end
            (c >= BASE_16x16 && c < NUM_ENT): begin
                rel = c - BASE_16x16;
                sad = SEL_W'(s16x16[rel*W_16x16 +: W_16x16]);
                typ = SAD_T_16x16;
            end
            default: ;
        endcase
        idx = 5'(rel);
    end

endmodule

// File: rtl/sad_min_drain.sv
// Snapshot and stream-out of per-partition minimum SADs.
// Captures on sweep_done, pulses clr_min, drains 100 entries.
module sad_min_drain
    import me_sad_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sweep_done,
    input  logic [415:0]     min_SAD4x8,
    input  logic [415:0]     min_SAD8x4,
    input  logic [223:0]     min_SAD8x8,
    input  logic [119:0]     min_SAD8x16,
    input  logic [119:0]     min_SAD16x8,
    input  logic [63:0]      min_SAD16x16,
    output logic             clr_min,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sad,
    output logic [2:0]       out_type,
    output logic [4:0]       out_idx,
    output logic             out_last,
    output logic             overrun
);

    localparam logic [6:0] LAST_CNT = 7'(NUM_ENT - 1);

    state_t       state;
    logic [6:0]   cnt;
    logic [415:0] sh_4x8;
    logic [415:0] sh_8x4;
    logic [223:0] sh_8x8;
    logic [119:0] sh_8x16;
    logic [119:0] sh_16x8;
    logic [63:0]  sh_16x16;

    logic [SEL_W-1:0] sel_sad;
    logic [2:0]       sel_typ;
    logic [4:0]       sel_idx;
    logic             fire;
    logic             at_last;

    assign fire    = out_valid && out_ready;
    assign at_last = (cnt == LAST_CNT);

    sad_entry_sel u_sel (
        .cnt    (cnt),
        .s4x8   (sh_4x8),
        .s8x4   (sh_8x4),
        .s8x8   (sh_8x8),
        .s8x16  (sh_8x16),
        .s16x8  (sh_16x8),
        .s16x16 (sh_16x16),
        .sad    (sel_sad),
        .typ    (sel_typ),
        .idx    (sel_idx)
    );

    // Data outputs read only registered state; forced to 0 when idle.
    assign out_sad  = out_valid ? OUT_W'(sel_sad) : '0;
    assign out_type = out_valid ? sel_typ : 3'd0;
    assign out_idx  = out_valid ? sel_idx : 5'd0;
    assign out_last = out_valid && at_last;

    // Drain FSM: snapshot on sweep_done, advance on each handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            clr_min   <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            sh_4x8    <= '0;
            sh_8x4    <= '0;
            sh_8x8    <= '0;
            sh_8x16   <= '0;
            sh_16x8   <= '0;
            sh_16x16  <= '0;
        end else begin
            clr_min <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (sweep_done) begin
                        sh_4x8    <= min_SAD4x8;
                        sh_8x4    <= min_SAD8x4;
                        sh_8x8    <= min_SAD8x8;
                        sh_8x16   <= min_SAD8x16;
                        sh_16x8   <= min_SAD16x8;
                        sh_16x16  <= min_SAD16x16;
                        cnt       <= '0;
                        clr_min   <= 1'b1;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (fire && at_last) begin
                        cnt <= '0;
                        if (sweep_done) begin
                            sh_4x8   <= min_SAD4x8;
                            sh_8x4   <= min_SAD8x4;
                            sh_8x8   <= min_SAD8x8;
                            sh_8x16  <= min_SAD8x16;
                            sh_16x8  <= min_SAD16x8;
                            sh_16x16 <= min_SAD16x16;
                            clr_min  <= 1'b1;
                        end else begin
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        if (fire) begin
                            cnt <= cnt + 7'd1;
                        end
                        if (sweep_done) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_min_drain.sv
// Scoreboard bench for sad_min_drain.
// Stimulus pushes expected entries; a monitor pops on handshakes.
module tb_sad_min_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         sweep_done;
    logic [415:0] min_SAD4x8;
    logic [415:0] min_SAD8x4;
    logic [223:0] min_SAD8x8;
    logic [119:0] min_SAD8x16;
    logic [119:0] min_SAD16x8;
    logic [63:0]  min_SAD16x16;
    logic         clr_min;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_sad;
    logic [2:0]   out_type;
    logic [4:0]   out_idx;
    logic         out_last;
    logic         overrun;

    always #5 clk = ~clk;

    sad_min_drain #(.OUT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .sweep_done   (sweep_done),
        .min_SAD4x8   (min_SAD4x8),
        .min_SAD8x4   (min_SAD8x4),
        .min_SAD8x8   (min_SAD8x8),
        .min_SAD8x16  (min_SAD8x16),
        .min_SAD16x8  (min_SAD16x8),
        .min_SAD16x16 (min_SAD16x16),
        .clr_min      (clr_min),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sad      (out_sad),
        .out_type     (out_type),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .overrun      (overrun)
    );

    typedef struct {
        int sad;
        int typ;
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q[$];

    int a48[32];
    int a84[32];
    int a88[16];
    int a816[8];
    int a168[8];
    int a1616[4];

    int checks = 0;
    int failures = 0;
    int hs_total = 0;
    int clr_cnt = 0;
    int ready_mode = 0;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 32; i++) min_SAD4x8[i*13 +: 13] = 13'(a48[i]);
        for (int i = 0; i < 32; i++) min_SAD8x4[i*13 +: 13] = 13'(a84[i]);
        for (int i = 0; i < 16; i++) min_SAD8x8[i*14 +: 14] = 14'(a88[i]);
        for (int i = 0; i < 8; i++) min_SAD8x16[i*15 +: 15] = 15'(a816[i]);
        for (int i = 0; i < 8; i++) min_SAD16x8[i*15 +: 15] = 15'(a168[i]);
        for (int i = 0; i < 4; i++) min_SAD16x16[i*16 +: 16] = 16'(a1616[i]);
    endtask

    // Reference stream: groups in fixed order, entry 99 flagged last.
    task automatic push_expected();
        exp_t e;
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            e = '{a48[i], 0, i, n == 99}; exp_q.push_back(e); n++;
        end
        for (int i = 0; i < 32; i++) begin
            e = '{a84[i], 1, i, n == 99}; exp_q.push_back(e); n++;
        end
        for (int i = 0; i < 16; i++) begin
            e = '{a88[i], 2, i, n == 99}; exp_q.push_back(e); n++;
        end
        for (int i = 0; i < 8; i++) begin
            e = '{a816[i], 3, i, n == 99}; exp_q.push_back(e); n++;
        end
        for (int i = 0; i < 8; i++) begin
            e = '{a168[i], 4, i, n == 99}; exp_q.push_back(e); n++;
        end
        for (int i = 0; i < 4; i++) begin
            e = '{a1616[i], 5, i, n == 99}; exp_q.push_back(e); n++;
        end
    endtask

    task automatic fill_basic();
        for (int i = 0; i < 32; i++) a48[i] = i + 1;
        for (int i = 0; i < 32; i++) a84[i] = 100 + i;
        for (int i = 0; i < 16; i++) a88[i] = 'h3FFF;
        for (int i = 0; i < 8; i++) a816[i] = i;
        for (int i = 0; i < 8; i++) a168[i] = 'h7FFF;
        for (int i = 0; i < 4; i++) a1616[i] = 'hFFFF;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) a48[i] = int'($urandom_range(0, 8191));
        for (int i = 0; i < 32; i++) a84[i] = int'($urandom_range(0, 8191));
        for (int i = 0; i < 16; i++) a88[i] = int'($urandom_range(0, 16383));
        for (int i = 0; i < 8; i++) a816[i] = int'($urandom_range(0, 32767));
        for (int i = 0; i < 8; i++) a168[i] = int'($urandom_range(0, 32767));
        for (int i = 0; i < 4; i++) a1616[i] = int'($urandom_range(0, 65535));
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 32; i++) a48[i] = 0;
        for (int i = 0; i < 32; i++) a84[i] = 0;
        for (int i = 0; i < 16; i++) a88[i] = 0;
        for (int i = 0; i < 8; i++) a816[i] = 0;
        for (int i = 0; i < 8; i++) a168[i] = 0;
        for (int i = 0; i < 4; i++) a1616[i] = 0;
    endtask

    // One-cycle sweep_done pulse; accepted pulses get an expected stream.
    task automatic sweep(bit accepted, bit zero_after);
        drive_inputs();
        sweep_done = 1'b1;
        if (accepted) push_expected();
        @(posedge clk);
        #1;
        sweep_done = 1'b0;
        if (zero_after) begin
            fill_zero();
            drive_inputs();
        end
        if (accepted) begin
            check("clr_min_pulse", int'(clr_min), 1);
            check("busy_after_sweep", int'(busy), 1);
            check("valid_after_sweep", int'(out_valid), 1);
            @(posedge clk);
            #1;
            check("clr_min_one_cycle", int'(clr_min), 0);
        end else begin
            check("clr_min_ignored", int'(clr_min), 0);
            check("overrun_set", int'(overrun), 1);
        end
    endtask

    task automatic wait_idle(string name);
        int cyc;
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_busy_done"}, int'(busy), 0);
        check({name, "_valid_done"}, int'(out_valid), 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_hs(int target);
        int cyc;
        cyc = 0;
        while (hs_total < target && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("wait_hs_timeout", int'(hs_total >= target), 1);
    endtask

    // Ready generator: tied high, ~30% random duty, or held low.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 99) < 30);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: compare on handshakes, check stability while stalled.
    logic        stall = 1'b0;
    logic [15:0] p_sad;
    logic [2:0]  p_typ;
    logic [4:0]  p_idx;
    logic        p_last;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (clr_min) clr_cnt++;
            if (stall && out_valid) begin
                check("stall_sad", int'(out_sad), int'(p_sad));
                check("stall_type", int'(out_type), int'(p_typ));
                check("stall_idx", int'(out_idx), int'(p_idx));
                check("stall_last", int'(out_last), int'(p_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_entry", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("entry_sad", int'(out_sad), e.sad);
                    check("entry_type", int'(out_type), e.typ);
                    check("entry_idx", int'(out_idx), e.idx);
                    check("entry_last", int'(out_last), int'(e.last));
                end
                hs_total++;
            end
            stall  = out_valid && !out_ready;
            p_sad  = out_sad;
            p_typ  = out_type;
            p_idx  = out_idx;
            p_last = out_last;
        end
    end

    initial begin
        int c0;
        int base;
        rst = 1'b1;
        sweep_done = 1'b0;
        out_ready = 1'b1;
        fill_zero();
        drive_inputs();
        #12;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_clr", int'(clr_min), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_sad", int'(out_sad), 0);
        check("rst_type", int'(out_type), 0);
        check("rst_idx", int'(out_idx), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic drain with fixed pattern
        ready_mode = 0;
        fill_basic();
        sweep(1'b1, 1'b0);
        wait_idle("basic");

        // Random backpressure
        ready_mode = 1;
        fill_random();
        sweep(1'b1, 1'b0);
        wait_idle("backpressure");

        // Inputs zeroed right after capture
        fill_random();
        sweep(1'b1, 1'b1);
        wait_idle("isolation");

        // Held-low ready stalls without loss
        ready_mode = 2;
        fill_random();
        sweep(1'b1, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        check("stall_valid_held", int'(out_valid), 1);
        check("stall_queue_full", exp_q.size(), 100);
        ready_mode = 0;
        wait_idle("stalled");

        // Back-to-back: new sweep on the final handshake edge
        ready_mode = 0;
        fill_random();
        sweep(1'b1, 1'b0);
        begin
            int cyc;
            cyc = 0;
            @(negedge clk);
            while (!(out_valid && out_last && out_ready) && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            check("b2b_found_last", int'(out_last), 1);
        end
        fill_random();
        sweep(1'b1, 1'b0);
        check("b2b_overrun", int'(overrun), 0);
        wait_idle("b2b");

        // Overrun: second pulse at counter 40
        ready_mode = 1;
        fill_random();
        base = hs_total;
        sweep(1'b1, 1'b0);
        c0 = clr_cnt;
        wait_hs(base + 40);
        fill_random();
        sweep(1'b0, 1'b0);
        wait_idle("overrun");
        check("overrun_sticky", int'(overrun), 1);
        check("overrun_no_clr", clr_cnt, c0);

        // Reset mid-drain
        ready_mode = 0;
        fill_random();
        base = hs_total;
        sweep(1'b1, 1'b0);
        wait_hs(base + 50);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_clr", int'(clr_min), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_held_valid", int'(out_valid), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_clr", int'(clr_min), 0);

        // Fresh drain after reset
        ready_mode = 1;
        fill_random();
        sweep(1'b1, 1'b0);
        wait_idle("fresh");
        check("fresh_overrun", int'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sad_min_drain.md
Name: sad_min_drain

Overview:
- Read side of the minimum-SAD comparator bank.
- On an end-of-sweep pulse it snapshots all 100 per-partition minimum SADs (4x8, 8x4, 8x8, 8x16, 16x8, 16x16) into shadow registers.
- It pulses a clear request back to the comparator bank, then streams the entries one per valid/ready handshake to the mode-decision stage.
- It sits between the comparator bank and the RD/mode-decision logic in the ME datapath.

Parameters:
- OUT_W, 16, width of out_sad. Values are zero-extended. Legal range 16..32.
- NUM_ENT, 100, localparam entry count (32+32+16+8+8+4). Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- sweep_done  in  1  single-cycle pulse: comparator minima are final for this search window
- min_SAD4x8  in  416  32 x 13-bit, entry i at [i*13+12:i*13]
- min_SAD8x4  in  416  32 x 13-bit, same packing
- min_SAD8x8  in  224  16 x 14-bit, entry j at [j*14+13:j*14]
- min_SAD8x16  in  120  8 x 15-bit
- min_SAD16x8  in  120  8 x 15-bit
- min_SAD16x16  in  64  4 x 16-bit
- clr_min  out  1  one-cycle request to reinitialise comparator minima
- busy  out  1  high while draining
- out_valid  out  1  entry available
- out_ready  in  1  downstream accepts entry
- out_sad  out  OUT_W  zero-extended SAD
- out_type  out  3  0=4x8, 1=8x4, 2=8x8, 3=8x16, 4=16x8, 5=16x16
- out_idx  out  5  index within type
- out_last  out  1  high on entry 99
- overrun  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, clr_min=0, busy=0, out_valid=0, out_last=0, overrun=0, out_sad/out_type/out_idx=0. Shadow registers are cleared to 0.
- FSM has two states: IDLE and SEND.
- IDLE, sweep_done=1 at edge N:
  - Capture all six input vectors into shadow.
  - counter<=0; go to SEND.
  - Cycle N+1: clr_min=1 for exactly one cycle; busy=1; out_valid=1.
- SEND:
  - out_valid=1.
  - Outputs are a function of counter and shadow only (registered state). They are stable while out_valid & !out_ready.
  - A handshake (valid & ready at an edge) increments counter.
  - The handshake with counter=99 returns to IDLE: out_valid=0, busy=0 next cycle.
- Stream order:
  - counter 0-31: 4x8 idx 0-31
  - 32-63: 8x4 idx 0-31
  - 64-79: 8x8 idx 0-15
  - 80-87: 8x16 idx 0-7
  - 88-95: 16x8 idx 0-7
  - 96-99: 16x16 idx 0-3
- Width: out_sad is the entry zero-extended to OUT_W; no saturation. out_last=1 iff counter=99.
- Boundary and error cases:
  - sweep_done in SEND without a final handshake in the same cycle: pulse ignored; shadow unchanged; overrun<=1 (sticky until reset); no clr_min.
  - sweep_done coincident with the counter=99 handshake: accepted. New snapshot, counter<=0, stay in SEND, clr_min pulses next cycle, overrun unchanged.
  - Inputs are sampled only on the capture edge. Later changes do not affect the stream.
  - out_ready held low: stall indefinitely, no data loss.
  - rst mid-drain: immediate abort to reset values; no partial output; clr_min is not issued.
- Throughput: 100 cycles minimum per drain with out_ready tied high. First entry appears 1 cycle after sweep_done.

Decomposition:
- Shared package me_sad_pkg holds:
  - Type-code constants (SAD_T_4x8..SAD_T_16x16).
  - Per-type entry counts and widths (13,13,14,15,15,16).
  - Per-type base offsets (0,32,64,80,88,96).
  - NUM_ENT.
- One sub-module, sad_entry_sel: combinational mux from counter plus shadow vectors to {sad, type, idx}. It isolates the slicing arithmetic from the FSM.
- The FSM, snapshot and handshake logic stay in sad_min_drain.

Test Plan:
- Basic drain: set 4x8[i]=i+1, 8x4[i]=100+i, 8x8[j]=0x3FFF, 8x16[k]=k, 16x8[k]=0x7FFF, 16x16[l]=0xFFFF; pulse sweep_done; out_ready=1 -> clr_min high exactly 1 cycle after sweep_done. Required entries:
  - Entry 0 = {1,0,0}
  - Entry 33 = {101,1,1}
  - Entry 64 = {0x3FFF,2,0}
  - Entry 99 = {0xFFFF,5,3} with out_last=1
  - Then busy=0 after 100 handshakes.
- Backpressure: toggle out_ready with a random 30% duty -> exactly 100 transfers in order; outputs never change while valid & !ready.
- Snapshot isolation: change all inputs to 0 one cycle after sweep_done -> the stream still carries the original values.
- Overrun: second sweep_done at drain counter 40 -> overrun=1, stream continues to entry 99 unchanged, no second clr_min.
- Back-to-back: sweep_done on the same edge as the counter=99 handshake -> new stream starts at entry 0 next cycle, clr_min pulses, overrun stays 0.
- Reset mid-drain: assert rst at counter 50 -> out_valid/busy/overrun/clr_min immediately 0. After release, a fresh sweep_done drains from entry 0.
